// File: rtl/mdio_pkg.sv
// mdio_pkg: shared MDIO frame constants, controller state encodings and frame builder
package mdio_pkg;
  localparam int PREAMBLE_LEN = 32;
  localparam int FRAME_LEN = 64;
  localparam logic [1:0] ST = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ = 2'b10;
  localparam logic [1:0] TA_WRITE = 2'b10;
  typedef logic [2:0] state_t;
  localparam state_t S_PHY_RST = 3'd0;
  localparam state_t S_PHY_WAIT = 3'd1;
  localparam state_t S_IDLE = 3'd2;
  localparam state_t S_SHIFT = 3'd3;
  localparam state_t S_DONE = 3'd4;
  // Read frames carry ones after REGAD; those bits are never driven since mdio_oe drops at TA.
  function automatic logic [FRAME_LEN-1:0] build_frame(input logic rd, input logic [4:0] pa,
                                                       input logic [4:0] ra, input logic [15:0] wd);
    return {{PREAMBLE_LEN{1'b1}}, ST, rd ? OP_READ : OP_WRITE, pa, ra,
            rd ? 2'b11 : TA_WRITE, rd ? 16'hFFFF : wd};
  endfunction
endpackage

// File: rtl/mdio_controller_if.sv
// mdio_controller_if: command/response handshake between a host and the MDIO controller
interface mdio_controller_if;
  logic cmd_valid;
  logic cmd_ready;
  logic cmd_read;
  logic [4:0] cmd_phy_addr;
  logic [4:0] cmd_reg_addr;
  logic [15:0] cmd_wdata;
  logic rsp_valid;
  logic [15:0] rsp_rdata;
  logic rsp_err;
  modport master (output cmd_valid, cmd_read, cmd_phy_addr, cmd_reg_addr, cmd_wdata,
                  input cmd_ready, rsp_valid, rsp_rdata, rsp_err);
  modport slave (input cmd_valid, cmd_read, cmd_phy_addr, cmd_reg_addr, cmd_wdata,
                 output cmd_ready, rsp_valid, rsp_rdata, rsp_err);
endinterface

// File: rtl/mdio_controller_mdc_gen.sv
// mdc_gen: MDC divider; rise/fall strobe in the last cycle before mdc toggles
module mdc_gen #(
  parameter int P_CLK_DIV = 25
) (
  input  logic mac_clk,
  input  logic rst,
  input  logic en,
  output logic mdc,
  output logic rise,
  output logic fall
);
  localparam int W = $clog2(P_CLK_DIV);
  logic [W-1:0] cnt_q, cnt_d;
  logic mdc_q, mdc_d, wrap;
  // half-period counter; disabled divider parks mdc low with the count cleared
  always_comb begin
    wrap = cnt_q == W'(P_CLK_DIV - 1);
    cnt_d = (!en || wrap) ? '0 : cnt_q + 1'b1;
    mdc_d = en && (wrap ? !mdc_q : mdc_q);
  end
  // divider state
  always_ff @(posedge mac_clk) begin
    if (rst) begin
      cnt_q <= '0;
      mdc_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      mdc_q <= mdc_d;
    end
  end
  assign mdc = mdc_q;
  assign rise = en && wrap && !mdc_q;
  assign fall = en && wrap && mdc_q;
endmodule

// File: rtl/mdio_controller.sv
// mdio_controller: PHY reset sequencing plus clause-22 MDIO read/write frame engine
module mdio_controller
  import mdio_pkg::*;
#(
  parameter int P_CLK_DIV = 25,
  parameter int P_PHY_RST_CYCLES = 125000,
  parameter int P_PHY_WAIT_CYCLES = 625000
) (
  input  logic mac_clk,
  input  logic rst,
  mdio_controller_if.slave bus,
  output logic busy,
  output logic phy_rst_n,
  output logic mdc,
  output logic mdio_o,
  output logic mdio_oe,
  input  logic mdio_i
);
  localparam int TMAX = P_PHY_RST_CYCLES > P_PHY_WAIT_CYCLES ? P_PHY_RST_CYCLES : P_PHY_WAIT_CYCLES;
  localparam int TW = $clog2(TMAX + 1);
  state_t state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [5:0] bit_q, bit_d;
  logic [FRAME_LEN-1:0] sh_q, sh_d;
  logic rd_q, rd_d, err_q, err_d;
  logic [15:0] rdata_q, rdata_d;
  logic rise, fall;
  mdc_gen #(.P_CLK_DIV(P_CLK_DIV)) u_mdc (
    .mac_clk(mac_clk),
    .rst(rst),
    .en(state_q == S_SHIFT),
    .mdc(mdc),
    .rise(rise),
    .fall(fall)
  );
  // sequencing: reset hold, post-reset wait, command accept, bit shifting, response
  always_comb begin
    state_d = state_q;
    tmr_d = tmr_q;
    bit_d = bit_q;
    sh_d = sh_q;
    rd_d = rd_q;
    err_d = err_q;
    rdata_d = rdata_q;
    case (state_q)
      S_PHY_RST: begin
        tmr_d = tmr_q == TW'(P_PHY_RST_CYCLES - 1) ? '0 : tmr_q + 1'b1;
        state_d = tmr_q == TW'(P_PHY_RST_CYCLES - 1) ? S_PHY_WAIT : S_PHY_RST;
      end
      S_PHY_WAIT: begin
        tmr_d = tmr_q == TW'(P_PHY_WAIT_CYCLES - 1) ? '0 : tmr_q + 1'b1;
        state_d = tmr_q == TW'(P_PHY_WAIT_CYCLES - 1) ? S_IDLE : S_PHY_WAIT;
      end
      S_IDLE: begin
        if (bus.cmd_valid) begin
          state_d = S_SHIFT;
          bit_d = '0;
          sh_d = build_frame(bus.cmd_read, bus.cmd_phy_addr, bus.cmd_reg_addr, bus.cmd_wdata);
          rd_d = bus.cmd_read;
          err_d = 1'b0;
          rdata_d = '0;
        end
      end
      S_SHIFT: begin
        if (rise && rd_q && bit_q == 6'd47) err_d = mdio_i;
        if (rise && rd_q && bit_q >= 6'd48) rdata_d = {rdata_q[14:0], mdio_i};
        if (fall) begin
          sh_d = {sh_q[FRAME_LEN-2:0], 1'b1};
          bit_d = bit_q + 1'b1;
          state_d = bit_q == 6'(FRAME_LEN - 1) ? S_DONE : S_SHIFT;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_PHY_RST;
    endcase
  end
  // controller state; reset aborts any frame and restarts the PHY reset sequence
  always_ff @(posedge mac_clk) begin
    if (rst) begin
      state_q <= S_PHY_RST;
      tmr_q <= '0;
      bit_q <= '0;
      sh_q <= '1;
      rd_q <= 1'b0;
      err_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      tmr_q <= tmr_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      rd_q <= rd_d;
      err_q <= err_d;
      rdata_q <= rdata_d;
    end
  end
  assign bus.cmd_ready = state_q == S_IDLE;
  assign bus.rsp_valid = state_q == S_DONE;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err = err_q;
  assign busy = state_q != S_IDLE;
  assign phy_rst_n = state_q != S_PHY_RST;
  assign mdio_o = state_q == S_SHIFT ? sh_q[FRAME_LEN-1] : 1'b1;
  assign mdio_oe = state_q == S_SHIFT && (!rd_q || bit_q < 6'd46);
endmodule

// File: doc/mdio_controller.md
MDIO_CONTROLLER -- requirements
Module: mdio_controller

Interface
REQ-001 P_CLK_DIV, 25, mac_clk cycles per MDC half-period (min 2); 125 MHz / 50 = 2.5 MHz MDC.
REQ-002 P_PHY_RST_CYCLES, 125000, mac_clk cycles phy_rst_n held low after rst deasserts.
REQ-003 P_PHY_WAIT_CYCLES, 625000, mac_clk cycles after phy_rst_n rises before first command accepted.
REQ-004 mac_clk  in  1  sole clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 cmd_valid  in  1  command request.
REQ-007 cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
REQ-008 cmd_read  in  1  1 = read frame, 0 = write frame.
REQ-009 cmd_phy_addr  in  5  PHYAD.
REQ-010 cmd_reg_addr  in  5  REGAD.
REQ-011 cmd_wdata  in  16  write data; ignored for reads.
REQ-012 rsp_valid  out  1  one-cycle pulse, frame complete.
REQ-013 rsp_rdata  out  16  read data, valid with rsp_valid; 0 for writes.
REQ-014 rsp_err  out  1  read saw no PHY turnaround drive, valid with rsp_valid.
REQ-015 busy  out  1  high in any state except IDLE.
REQ-016 phy_rst_n  out  1  PHY hardware reset, active-low.
REQ-017 mdc  out  1  management clock.
REQ-018 mdio_o / mdio_oe / mdio_i  out/out/in  1 each  MDIO tristate split; top-level buffer drives pad when mdio_oe=1.

Function
REQ-019 States PHY_RST -> PHY_WAIT -> IDLE -> SHIFT -> DONE -> IDLE; PHY_RST lasts P_PHY_RST_CYCLES, PHY_WAIT lasts P_PHY_WAIT_CYCLES.
REQ-020 cmd_ready = 1 only in IDLE; command fields registered on acceptance; inputs may change afterwards.
REQ-021 Frame is 64 bits MSB-first: 32 ones, ST=01, OP (write 01, read 10), PHYAD[4:0], REGAD[4:0], TA, DATA[15:0].
REQ-022 Write TA = 10 driven by controller; mdio_oe=1 for all 64 bits.
REQ-023 Read: mdio_oe=1 for bits 0..45, 0 for bits 46..63.
REQ-024 Each bit: mdc low for P_CLK_DIV cycles, then high for P_CLK_DIV cycles; mdio_o/mdio_oe update in the cycle mdc falls (or the first SHIFT cycle).
REQ-025 Read sampling: mdio_i captured in the cycle mdc rises, bits 47..63; bit 47 is TA-zero, bits 48..63 form rsp_rdata MSB-first.
REQ-026 rsp_err=1 if sampled bit 47 is 1; rsp_rdata still reports sampled bits (0xFFFF with pulled-up bus).
REQ-027 SHIFT entered the cycle after acceptance; DONE entered after bit 63 high half; rsp_valid pulses in DONE, exactly 128*P_CLK_DIV+1 cycles after acceptance cycle.
REQ-028 DONE returns to IDLE next cycle; back-to-back commands accepted the cycle after rsp_valid; no extra preamble gap.
REQ-029 Idle bus: mdc=0, mdio_o=1, mdio_oe=0.
REQ-030 cmd_valid outside IDLE is ignored (not queued); no response without acceptance.

Reset
REQ-031 rst (any state, incl. mid-frame) -> next cycle: PHY_RST, counters 0, cmd_ready=0, busy=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, phy_rst_n=0, mdc=0, mdio_o=1, mdio_oe=0; aborted frame produces no rsp_valid.
REQ-032 PHY_RST counting starts the first cycle rst is low.

Structure
REQ-033 Shared package mdio_pkg: op encodings (01 write, 10 read), ST=01, preamble length 32, frame length 64, state enum.
REQ-034 One sub-module mdc_gen: divider producing mdc plus one-cycle rise/fall strobes, cleared by rst and enabled only in SHIFT.

Verification
REQ-035 P_CLK_DIV=2, P_PHY_RST_CYCLES=8, P_PHY_WAIT_CYCLES=4: rst 3 cycles -> phy_rst_n low 8 cycles after release, cmd_ready rises 4 cycles later.
REQ-036 Write phy 1 reg 0 data 0x1140 -> mdio_o = 32x1,01,01,00001,00000,10,0001000101000000; rsp_valid 257 cycles after acceptance, rsp_err=0, rsp_rdata=0.
REQ-037 Read phy 1 reg 2, PHY model drives TA 0 and 0x004D -> mdio_oe falls at bit 46, rsp_rdata=0x004D, rsp_err=0.
REQ-038 Read with no PHY (mdio_i held 1) -> rsp_rdata=0xFFFF, rsp_err=1.
REQ-039 cmd_valid held for two writes -> second accepted cycle after first rsp_valid; extra cmd_valid pulses mid-frame produce no response.
REQ-040 rst asserted at bit 40 of a read -> next cycle mdc=0, mdio_oe=0, phy_rst_n=0, no rsp_valid; full PHY_RST/PHY_WAIT sequence repeats.
